// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: request record, FSM states, port ids.
package mem_arb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  typedef enum logic {PORT_I, PORT_D} port_id_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One-entry request holding register for a requester port, with protocol-error detection.
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  mem_req_t req_in,
  input  logic     clear,
  output logic     valid,
  output mem_req_t req,
  output logic     err
);

  logic     valid_q, valid_d;
  mem_req_t req_q, req_d;
  logic     new_req, bad, load;

  // A slot completing on this edge counts as free, so back-to-back requests are accepted.
  always_comb begin
    new_req = (req_in.rmask != 4'h0) || (req_in.wmask != 4'h0);
    bad     = (valid_q && !clear)
           || ((req_in.rmask != 4'h0) && (req_in.wmask != 4'h0))
           || (req_in.addr[1:0] != 2'b00);
    load    = new_req && !bad;
    err     = new_req && bad;
    valid_d = load ? 1'b1 : (clear ? 1'b0 : valid_q);
    req_d   = load ? req_in : req_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid = valid_q;
  assign req   = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between I and D requesters,
// one transaction in flight, with a WAIT timeout and a sticky protocol-error flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_rmask,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  mem_req_t i_in, d_in, i_req, d_req, sel;
  logic     i_vld, d_vld, i_err, d_err, i_clr, d_clr;

  assign i_in = '{addr: i_addr, rmask: i_rmask, wmask: 4'h0, wdata: 32'h0};
  assign d_in = '{addr: d_addr, rmask: d_rmask, wmask: d_wmask, wdata: d_wdata};

  mem_arb_slot u_slot_i (.clk(clk), .rst(rst), .req_in(i_in), .clear(i_clr),
                         .valid(i_vld), .req(i_req), .err(i_err));
  mem_arb_slot u_slot_d (.clk(clk), .rst(rst), .req_in(d_in), .clear(d_clr),
                         .valid(d_vld), .req(d_req), .err(d_err));

  arb_state_t    state_q, state_d;
  port_id_t      gnt_q, gnt_d, last_q, last_d, pick;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_rmask_q, mem_rmask_d, mem_wmask_q, mem_wmask_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_resp_q, i_resp_d, d_resp_q, d_resp_d, error_q, error_d;
  logic          done, g_is_read;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    timer_d     = timer_q;
    mem_addr_d  = mem_addr_q;
    mem_rmask_d = mem_rmask_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    error_d     = error_q | i_err | d_err;
    done        = 1'b0;
    pick        = PORT_I;
    sel         = i_req;
    g_is_read   = (gnt_q == PORT_I) ? 1'b1 : (d_req.rmask != 4'h0);

    case (state_q)
      IDLE: begin
        if (mem_resp) error_d = 1'b1;
        if (i_vld || d_vld) begin
          if (i_vld && d_vld) pick = (last_q == PORT_I) ? PORT_D : PORT_I;
          else                pick = i_vld ? PORT_I : PORT_D;
          sel         = (pick == PORT_I) ? i_req : d_req;
          gnt_d       = pick;
          mem_addr_d  = sel.addr;
          mem_rmask_d = sel.rmask;
          mem_wmask_d = sel.wmask;
          mem_wdata_d = sel.wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_rmask_d = 4'h0;
        mem_wmask_d = 4'h0;
        timer_d     = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (mem_resp) begin
          done = 1'b1;
          if (g_is_read) begin
            if (gnt_q == PORT_I) i_rdata_d = mem_rdata;
            else                 d_rdata_d = mem_rdata;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          done    = 1'b1;
          error_d = 1'b1;
          if (gnt_q == PORT_I) i_rdata_d = 32'h0;
          else                 d_rdata_d = 32'h0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      i_resp_d = (gnt_q == PORT_I);
      d_resp_d = (gnt_q == PORT_D);
      last_d   = gnt_q;
      state_d  = IDLE;
    end
  end

  assign i_clr = i_resp_d;
  assign d_clr = d_resp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= PORT_I;
      last_q      <= PORT_D;
      timer_q     <= '0;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
      error_q     <= error_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_rdata   = d_rdata_q;
  assign d_resp    = d_resp_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rmask = mem_rmask_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign error     = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (timeout shortened to 8 cycles).
module tb_mem_port_arbiter;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  i_rmask = '0, d_rmask = '0, d_wmask = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        i_resp, d_resp, error;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rmask = '0; d_rmask = '0; d_wmask = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    mem_resp = 1'b0;
    #1;
    chk("rst_outs", {31'h0, i_resp | d_resp | error | (|mem_rmask) | (|mem_wmask)}, 32'h0);
    chk("rst_rdata", i_rdata | d_rdata | mem_addr, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (mem_rmask == 4'h0 && mem_wmask == 4'h0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_issued"}, {31'h0, n < 20}, 32'h1);
  endtask

  // Wait for an issued access, check it, then answer with a one-cycle memory.
  task automatic mem_txn(input string tag, input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] rd);
    wait_issue(tag);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_masks"}, {24'h0, mem_rmask, mem_wmask}, {24'h0, rm, wm});
    if (wm != 4'h0) chk({tag, "_wdata"}, mem_wdata, wd);
    tick();
    chk({tag, "_mask_1cyc"}, {24'h0, mem_rmask, mem_wmask}, 32'h0);
    mem_resp = 1'b1; mem_rdata = rd;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic no_traffic(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      chk(tag, {24'h0, mem_rmask, mem_wmask}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    apply_reset();

    // Single I read, exact latency, plus a new request on the completion edge.
    i_addr = 32'h100; i_rmask = 4'hF;
    tick();
    idle_inputs();
    chk("t1_e0_mask", {28'h0, mem_rmask}, 32'h0);
    tick();
    chk("t1_e1_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("t1_e1_addr", mem_addr, 32'h100);
    tick();
    chk("t1_e2_rmask", {28'h0, mem_rmask}, 32'h0);
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    i_addr = 32'h104; i_rmask = 4'hF;
    tick();
    mem_resp = 1'b0; mem_rdata = '0; idle_inputs();
    chk("t1_e3_resp", {31'h0, i_resp}, 32'h1);
    chk("t1_e3_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_err", {31'h0, error}, 32'h0);
    tick();
    chk("t1_resp_pulse", {31'h0, i_resp}, 32'h0);
    chk("t1_rdata_hold", i_rdata, 32'hDEADBEEF);
    mem_txn("t1b", 32'h104, 4'hF, 4'h0, 32'h0, 32'h11111111);
    chk("t1b_resp", {31'h0, i_resp}, 32'h1);
    chk("t1b_rdata", i_rdata, 32'h11111111);
    chk("t1b_err", {31'h0, error}, 32'h0);

    // Simultaneous pair after reset: I first, then D; later pair with last=I: D first.
    apply_reset();
    i_addr = 32'h10; i_rmask = 4'hF; d_addr = 32'h20; d_rmask = 4'hF;
    tick();
    idle_inputs();
    mem_txn("t2_i", 32'h10, 4'hF, 4'h0, 32'h0, 32'hAAAA0010);
    chk("t2_i_resp", {30'h0, i_resp, d_resp}, 32'h2);
    chk("t2_i_rdata", i_rdata, 32'hAAAA0010);
    mem_txn("t2_d", 32'h20, 4'hF, 4'h0, 32'h0, 32'hBBBB0020);
    chk("t2_d_resp", {30'h0, i_resp, d_resp}, 32'h1);
    chk("t2_d_rdata", d_rdata, 32'hBBBB0020);
    i_addr = 32'h30; i_rmask = 4'hF;
    tick();
    idle_inputs();
    mem_txn("t2_i2", 32'h30, 4'hF, 4'h0, 32'h0, 32'hC0C0C0C0);
    chk("t2_i2_rdata", i_rdata, 32'hC0C0C0C0);
    i_addr = 32'h34; i_rmask = 4'hF; d_addr = 32'h24; d_rmask = 4'hF;
    tick();
    idle_inputs();
    mem_txn("t2_pair2_d", 32'h24, 4'hF, 4'h0, 32'h0, 32'hD0D0D0D0);
    chk("t2_pair2_d_resp", {30'h0, i_resp, d_resp}, 32'h1);
    chk("t2_pair2_d_rdata", d_rdata, 32'hD0D0D0D0);
    mem_txn("t2_pair2_i", 32'h34, 4'hF, 4'h0, 32'h0, 32'hE0E0E0E0);
    chk("t2_pair2_i_resp", {30'h0, i_resp, d_resp}, 32'h2);
    chk("t2_pair2_i_rdata", i_rdata, 32'hE0E0E0E0);

    // D write then read of the same word; d_rdata moves only on the read.
    d_addr = 32'h40; d_wmask = 4'h3; d_wdata = 32'h1234;
    tick();
    idle_inputs();
    mem_txn("t3_wr", 32'h40, 4'h0, 4'h3, 32'h1234, 32'hFFFFFFFF);
    chk("t3_wr_resp", {31'h0, d_resp}, 32'h1);
    chk("t3_wr_rdata_hold", d_rdata, 32'hD0D0D0D0);
    tick();
    chk("t3_wr_resp_pulse", {31'h0, d_resp}, 32'h0);
    d_addr = 32'h40; d_rmask = 4'hF;
    tick();
    idle_inputs();
    mem_txn("t3_rd", 32'h40, 4'hF, 4'h0, 32'h0, 32'h1234);
    chk("t3_rd_resp", {31'h0, d_resp}, 32'h1);
    chk("t3_rd_rdata", d_rdata, 32'h1234);
    chk("t3_err", {31'h0, error}, 32'h0);

    // Misaligned address is refused.
    d_addr = 32'h42; d_rmask = 4'hF;
    tick();
    idle_inputs();
    chk("t3m_err", {31'h0, error}, 32'h1);
    no_traffic("t3m_dropped", 4);

    // Occupied I slot and read+write D request are both dropped.
    apply_reset();
    i_addr = 32'h50; i_rmask = 4'hF;
    tick();
    i_addr = 32'h54; i_rmask = 4'hF; d_addr = 32'h60; d_rmask = 4'hF; d_wmask = 4'hF;
    tick();
    idle_inputs();
    chk("t4_err", {31'h0, error}, 32'h1);
    mem_txn("t4_i", 32'h50, 4'hF, 4'h0, 32'h0, 32'h5050);
    chk("t4_i_resp", {31'h0, i_resp}, 32'h1);
    chk("t4_i_rdata", i_rdata, 32'h5050);
    no_traffic("t4_dropped", 5);
    chk("t4_err_sticky", {31'h0, error}, 32'h1);

    // Timeout with TIMEOUT_CYCLES=8.
    apply_reset();
    i_addr = 32'h60; i_rmask = 4'hF;
    tick();
    idle_inputs();
    mem_txn("t5_pre", 32'h60, 4'hF, 4'h0, 32'h0, 32'hCAFE);
    chk("t5_pre_rdata", i_rdata, 32'hCAFE);
    i_addr = 32'h64; i_rmask = 4'hF;
    tick();
    idle_inputs();
    wait_issue("t5");
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_wait", {30'h0, i_resp, error}, 32'h0);
    end
    tick();
    chk("t5_to_resp", {31'h0, i_resp}, 32'h1);
    chk("t5_to_rdata", i_rdata, 32'h0);
    chk("t5_to_err", {31'h0, error}, 32'h1);
    tick();
    chk("t5_to_pulse", {31'h0, i_resp}, 32'h0);
    d_addr = 32'h68; d_rmask = 4'hF;
    tick();
    idle_inputs();
    mem_txn("t5_after", 32'h68, 4'hF, 4'h0, 32'h0, 32'h6868);
    chk("t5_after_resp", {31'h0, d_resp}, 32'h1);
    chk("t5_after_rdata", d_rdata, 32'h6868);

    // Reset during WAIT, then a late memory response in IDLE.
    i_addr = 32'h70; i_rmask = 4'hF;
    tick();
    idle_inputs();
    wait_issue("t6");
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_flags", {28'h0, i_resp, d_resp, error, |mem_rmask}, 32'h0);
    chk("t6_async_data", d_rdata | mem_addr, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_stray", {26'h0, i_resp, d_resp, mem_rmask}, 32'h0);
    end
    mem_resp = 1'b1; mem_rdata = 32'h7777;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    chk("t6_late_err", {31'h0, error}, 32'h1);
    chk("t6_late_noresp", {30'h0, i_resp, d_resp}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
